// File: rtl/calc_op_sequencer_pkg.sv
// Shared definitions for the calculator operation sequencer: operator codes,
// error codes, FSM states and default datapath widths.
package calc_op_sequencer_pkg;

    localparam int OPW_DEF  = 12;
    localparam int RESW_DEF = 20;
    localparam int CNT_W    = 10;

    localparam logic [3:0] OP_DIV = 4'hC;
    localparam logic [3:0] OP_MUL = 4'hD;
    localparam logic [3:0] OP_SUB = 4'hE;
    localparam logic [3:0] OP_ADD = 4'hF;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'b00,
        ERR_DIV0    = 2'b01,
        ERR_TIMEOUT = 2'b10,
        ERR_BADOP   = 2'b11
    } err_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_LOAD,
        ST_RUN,
        ST_CAPTURE,
        ST_HOLD
    } state_e;

    function automatic logic is_valid_op(input logic [3:0] op);
        return (op == OP_DIV) || (op == OP_MUL) || (op == OP_SUB) || (op == OP_ADD);
    endfunction

    function automatic logic is_iterative(input logic [3:0] op);
        return (op == OP_DIV) || (op == OP_MUL);
    endfunction

endpackage

// File: rtl/calc_op_sequencer_if.sv
// Request, ALU-strobe and result signals between keypad FSM, ALU, display
// and the sequencer. The sequencer uses the slave modport.
interface calc_op_sequencer_if
    import calc_op_sequencer_pkg::*;
#(
    parameter int OPW  = OPW_DEF,
    parameter int RESW = RESW_DEF
);
    logic            req_valid;
    logic            req_ready;
    logic [OPW-1:0]  req_num0;
    logic [OPW-1:0]  req_num1;
    logic            req_sign0;
    logic            req_sign1;
    logic [3:0]      req_op;
    logic            abort;

    logic            alu_clear;
    logic            alu_load;
    logic            alu_enable;
    logic [OPW-1:0]  alu_num0;
    logic [OPW-1:0]  alu_num1;
    logic            alu_sign0;
    logic            alu_sign1;
    logic [3:0]      alu_op;
    logic            alu_done;
    logic [RESW-1:0] alu_result;
    logic [RESW-1:0] alu_rem;
    logic            alu_signout;

    logic            res_valid;
    logic            res_ack;
    logic [RESW-1:0] res_value;
    logic [RESW-1:0] res_rem;
    logic            res_sign;
    logic [1:0]      err_code;
    logic            busy;

    modport slave (
        input  req_valid, req_num0, req_num1, req_sign0, req_sign1, req_op, abort,
        input  alu_done, alu_result, alu_rem, alu_signout, res_ack,
        output req_ready, alu_clear, alu_load, alu_enable,
        output alu_num0, alu_num1, alu_sign0, alu_sign1, alu_op,
        output res_valid, res_value, res_rem, res_sign, err_code, busy
    );

    modport master (
        output req_valid, req_num0, req_num1, req_sign0, req_sign1, req_op, abort,
        output alu_done, alu_result, alu_rem, alu_signout, res_ack,
        input  req_ready, alu_clear, alu_load, alu_enable,
        input  alu_num0, alu_num1, alu_sign0, alu_sign1, alu_op,
        input  res_valid, res_value, res_rem, res_sign, err_code, busy
    );

endinterface

// File: rtl/calc_op_sequencer_op_timeout_counter.sv
// Saturating enable-cycle counter; expired_o flags the cycle on which the
// current enabled cycle is the limit-th one since the last clear.
module calc_op_sequencer_op_timeout_counter
    import calc_op_sequencer_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic             enable_i,
    input  logic [CNT_W-1:0] limit_i,
    output logic             expired_o
);
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = ({1'b0, count_q} + 1'b1) >= {1'b0, limit_i};

endmodule

// File: rtl/calc_op_sequencer.sv
// Sequences one calculator operation through the BCD ALU: clear, load, run
// until done/timeout, capture, then hold the result for the display.
module calc_op_sequencer
    import calc_op_sequencer_pkg::*;
#(
    parameter int OPW        = OPW_DEF,
    parameter int RESW       = RESW_DEF,
    parameter int MAX_CYCLES = 1000
) (
    input  logic                clock,
    input  logic                reset,
    calc_op_sequencer_if.slave  bus
);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_CYCLES);

    state_e          state_q,  state_d;
    logic [OPW-1:0]  num0_q,   num0_d;
    logic [OPW-1:0]  num1_q,   num1_d;
    logic            sign0_q,  sign0_d;
    logic            sign1_q,  sign1_d;
    logic [3:0]      op_q,     op_d;
    logic [RESW-1:0] value_q,  value_d;
    logic [RESW-1:0] rem_q,    rem_d;
    logic            rsign_q,  rsign_d;
    err_e            err_q,    err_d;
    logic            clr_q,    clr_d;
    logic            expired;

    calc_op_sequencer_op_timeout_counter u_timeout (
        .clk_i     (clock),
        .rst_i     (reset),
        .clear_i   (state_q == ST_LOAD),
        .enable_i  (state_q == ST_RUN),
        .limit_i   (LIMIT),
        .expired_o (expired)
    );

    always_comb begin
        state_d = state_q;
        num0_d  = num0_q;
        num1_d  = num1_q;
        sign0_d = sign0_q;
        sign1_d = sign1_q;
        op_d    = op_q;
        value_d = value_q;
        rem_d   = rem_q;
        rsign_d = rsign_q;
        err_d   = err_q;
        clr_d   = 1'b0;

        // Abort is a registered one-cycle ALU clear, issued while back in IDLE.
        if (bus.abort && ((state_q != ST_IDLE) || bus.req_valid)) begin
            state_d = ST_IDLE;
            err_d   = ERR_NONE;
            clr_d   = 1'b1;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        num0_d  = bus.req_num0;
                        num1_d  = bus.req_num1;
                        sign0_d = bus.req_sign0;
                        sign1_d = bus.req_sign1;
                        op_d    = bus.req_op;
                        value_d = '0;
                        rem_d   = '0;
                        rsign_d = 1'b0;
                        if (!is_valid_op(bus.req_op)) begin
                            err_d   = ERR_BADOP;
                            state_d = ST_HOLD;
                        end else if ((bus.req_op == OP_DIV) && (bus.req_num1 == '0)) begin
                            err_d   = ERR_DIV0;
                            state_d = ST_HOLD;
                        end else begin
                            err_d   = ERR_NONE;
                            state_d = ST_CLEAR;
                        end
                    end
                end
                ST_CLEAR: state_d = ST_LOAD;
                ST_LOAD:  state_d = ST_RUN;
                ST_RUN: begin
                    if (!is_iterative(op_q) || bus.alu_done) begin
                        state_d = ST_CAPTURE;
                    end else if (expired) begin
                        state_d = ST_HOLD;
                        err_d   = ERR_TIMEOUT;
                        value_d = '0;
                        rem_d   = '0;
                        rsign_d = 1'b0;
                    end
                end
                ST_CAPTURE: begin
                    value_d = bus.alu_result;
                    rem_d   = bus.alu_rem;
                    rsign_d = bus.alu_signout && (bus.alu_result != '0);
                    state_d = ST_HOLD;
                end
                ST_HOLD: begin
                    if (bus.res_ack) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            num0_q  <= '0;
            num1_q  <= '0;
            sign0_q <= 1'b0;
            sign1_q <= 1'b0;
            op_q    <= '0;
            value_q <= '0;
            rem_q   <= '0;
            rsign_q <= 1'b0;
            err_q   <= ERR_NONE;
            clr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            num0_q  <= num0_d;
            num1_q  <= num1_d;
            sign0_q <= sign0_d;
            sign1_q <= sign1_d;
            op_q    <= op_d;
            value_q <= value_d;
            rem_q   <= rem_d;
            rsign_q <= rsign_d;
            err_q   <= err_d;
            clr_q   <= clr_d;
        end
    end

    assign bus.req_ready  = (state_q == ST_IDLE);
    assign bus.busy       = (state_q != ST_IDLE);
    assign bus.alu_clear  = reset || (state_q == ST_CLEAR) || clr_q;
    assign bus.alu_load   = (state_q == ST_LOAD);
    assign bus.alu_enable = (state_q == ST_RUN);
    assign bus.alu_num0   = num0_q;
    assign bus.alu_num1   = num1_q;
    assign bus.alu_sign0  = sign0_q;
    assign bus.alu_sign1  = sign1_q;
    assign bus.alu_op     = op_q;
    assign bus.res_valid  = (state_q == ST_HOLD);
    assign bus.res_value  = value_q;
    assign bus.res_rem    = rem_q;
    assign bus.res_sign   = rsign_q;
    assign bus.err_code   = err_q;

endmodule
